// File: rtl/jump_index_encoder.sv
// Encodes a byte-address jump target into the 26-bit J-type instruction index.
// Alignment and region checks are applied, and results are queued in a small valid/ready FIFO.
module jump_index_encoder #(
    parameter int DEPTH     = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          target_addr,
    input  logic [31:0]          pc_plus4,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [25:0]          instr_index,
    output logic                 misaligned,
    output logic                 region_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 28;
    localparam logic [CNT_W-1:0]     DEPTH_C = CNT_W'(DEPTH);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    logic [ENT_W-1:0]     mem_q [DEPTH];
    logic [ENT_W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    logic [ENT_W-1:0] new_entry;
    logic [ENT_W-1:0] head_entry;
    logic             push;
    logic             pop;

    // The entry packs the index together with the misaligned and region_err flags (the two low bits).
    always_comb begin
        new_entry = {target_addr[27:2],
                     |target_addr[1:0],
                     target_addr[31:28] != pc_plus4[31:28]};
    end

    // The handshake depends only on the registered count, so out_ready has no path to in_ready.
    always_comb begin
        in_ready  = (count_q < DEPTH_C);
        out_valid = (count_q != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = new_entry;
        end

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        err_count_d = err_count_q;
        if (push && (new_entry[1] || new_entry[0]) && (err_count_q != ERR_MAX)) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_count_q <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_count_q <= err_count_d;
        end
    end

    // The head is zero-masked when the FIFO is empty, so stale slots never reach the outputs.
    always_comb begin
        head_entry  = out_valid ? mem_q[rd_ptr_q] : '0;
        instr_index = head_entry[ENT_W-1:2];
        misaligned  = head_entry[1];
        region_err  = head_entry[0];
        err_count   = err_count_q;
    end

endmodule

// File: tb/tb_jump_index_encoder.sv
// Directed bench for jump_index_encoder.
// The DUT uses a 2-bit error counter so that counter saturation can be reached in a few pushes.
module tb_jump_index_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] target_addr;
    logic [31:0] pc_plus4;
    logic        out_valid;
    logic        out_ready;
    logic [25:0] instr_index;
    logic        misaligned;
    logic        region_err;
    logic [1:0]  err_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    jump_index_encoder #(.DEPTH(2), .ERR_CNT_W(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .target_addr (target_addr),
        .pc_plus4    (pc_plus4),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .instr_index (instr_index),
        .misaligned  (misaligned),
        .region_err  (region_err),
        .err_count   (err_count)
    );

    // Advance past the next rising edge; inputs driven after this are stable for the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        target_addr = '0;
        pc_plus4    = '0;
        reset       = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        target_addr = '0;
        pc_plus4    = '0;
        reset       = 1'b1;
        #3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        checks++; if (instr_index !== 26'h0) begin errors++; $display("FAIL reset_index: got %h want 0", instr_index); end
        checks++; if ({misaligned, region_err} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {misaligned, region_err}); end
        checks++; if (err_count !== 2'd0) begin errors++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        tick();
    endtask

    task automatic test_single_aligned();
        do_reset();
        target_addr = 32'h0040_0024;
        pc_plus4    = 32'h0040_0004;
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass: got %0b want 0", out_valid); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b want 1", out_valid); end
        checks++; if (instr_index !== 26'h010_0009) begin errors++; $display("FAIL single_index: got %h want 0100009", instr_index); end
        checks++; if ({misaligned, region_err} !== 2'b00) begin errors++; $display("FAIL single_flags: got %b want 00", {misaligned, region_err}); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drained: got %0b want 0", out_valid); end
        checks++; if (err_count !== 2'd0) begin errors++; $display("FAIL single_err_count: got %0d want 0", err_count); end
        checks++; if (instr_index !== 26'h0) begin errors++; $display("FAIL single_empty_index: got %h want 0", instr_index); end
    endtask

    task automatic test_misaligned_region();
        do_reset();
        target_addr = 32'h1000_0006;
        pc_plus4    = 32'h0040_0004;
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (instr_index !== 26'h000_0001) begin errors++; $display("FAIL misreg_index: got %h want 0000001", instr_index); end
        checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL misreg_misaligned: got %0b want 1", misaligned); end
        checks++; if (region_err !== 1'b1) begin errors++; $display("FAIL misreg_region: got %0b want 1", region_err); end
        checks++; if (err_count !== 2'd1) begin errors++; $display("FAIL misreg_err_count: got %0d want 1", err_count); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL misreg_drained: got %0b want 0", out_valid); end
        // An aligned target in a different region must raise only region_err.
        out_ready   = 1'b0;
        target_addr = 32'h2000_0010;
        pc_plus4    = 32'h3000_0000;
        in_valid    = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if ({instr_index, misaligned, region_err} !== {26'h000_0004, 2'b01}) begin errors++; $display("FAIL region_only: got %h/%b want 0000004/01", instr_index, {misaligned, region_err}); end
        checks++; if (err_count !== 2'd2) begin errors++; $display("FAIL region_only_err_count: got %0d want 2", err_count); end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        pc_plus4  = 32'h0;
        in_valid  = 1'b1;
        target_addr = 32'h4;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_1: got %0b want 1", in_ready); end
        checks++; if (instr_index !== 26'h1) begin errors++; $display("FAIL bp_head_1: got %h want 1", instr_index); end
        target_addr = 32'h8;
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got %0b want 0", in_ready); end
        target_addr = 32'hC;
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_still_full: got %0b want 0", in_ready); end
        checks++; if (instr_index !== 26'h1) begin errors++; $display("FAIL bp_head_stable: got %h want 1", instr_index); end
        tick();
        checks++; if ({out_valid, instr_index} !== {1'b1, 26'h1}) begin errors++; $display("FAIL bp_head_stable2: got %b/%h want 1/1", out_valid, instr_index); end
        out_ready = 1'b1;
        tick();
        checks++; if (instr_index !== 26'h2) begin errors++; $display("FAIL bp_drain_2: got %h want 2", instr_index); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_slot_freed: got %0b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if ({out_valid, instr_index} !== {1'b1, 26'h3}) begin errors++; $display("FAIL bp_drain_3: got %b/%h want 1/3", out_valid, instr_index); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %0b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        pc_plus4    = 32'h0;
        out_ready   = 1'b0;
        target_addr = 32'h100;
        in_valid    = 1'b1;
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            target_addr = 32'h104 + 32'(4 * i);
            checks++; if ({out_valid, in_ready} !== 2'b11) begin errors++; $display("FAIL b2b_state_%0d: got %b want 11", i, {out_valid, in_ready}); end
            checks++; if (instr_index !== 26'(32'h40 + i)) begin errors++; $display("FAIL b2b_index_%0d: got %h want %h", i, instr_index, 26'(32'h40 + i)); end
            tick();
        end
        in_valid = 1'b0;
        checks++; if ({out_valid, in_ready, instr_index} !== {2'b11, 26'h4A}) begin errors++; $display("FAIL b2b_last: got %b/%h want 11/4a", {out_valid, in_ready}, instr_index); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %0b want 0", out_valid); end
    endtask

    task automatic test_saturation();
        do_reset();
        pc_plus4    = 32'h0;
        target_addr = 32'h1;
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (err_count !== 2'((i < 3) ? i + 1 : 3)) begin errors++; $display("FAIL sat_%0d: got %0d want %0d", i, err_count, (i < 3) ? i + 1 : 3); end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_mid_reset();
        do_reset();
        pc_plus4  = 32'h0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        target_addr = 32'h11;
        tick();
        target_addr = 32'h22;
        tick();
        in_valid = 1'b0;
        checks++; if ({out_valid, in_ready, err_count} !== {2'b10, 2'd2}) begin errors++; $display("FAIL midrst_pre: got %b/%0d want 10/2", {out_valid, in_ready}, err_count); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if ({out_valid, err_count} !== {1'b0, 2'd0}) begin errors++; $display("FAIL midrst_async: got %b/%0d want 0/0", out_valid, err_count); end
        checks++; if ({instr_index, misaligned, region_err} !== 28'h0) begin errors++; $display("FAIL midrst_fields: got %h want 0", {instr_index, misaligned, region_err}); end
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL midrst_release: got %b want 10", {in_ready, out_valid}); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale_%0d: got %0b want 0", i, out_valid); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_aligned();
        test_misaligned_region();
        test_backpressure();
        test_back_to_back();
        test_saturation();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
